// File: rtl/imm_decode_pipe_pkg.sv
// ============================================================================
// Package : opcode_type
// Desc    : RV32I/RV64I opcode, funct7 and immediate-format definitions.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package opcode_type;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] SYSTEM    = 7'b1110011;
  localparam logic [6:0] MISC_MEM  = 7'b0001111;

  localparam logic [6:0] FUNCT7_SRLI = 7'b0000000;
  localparam logic [6:0] FUNCT7_SRAI = 7'b0100000;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ZIMM  = 3'd7
  } imm_fmt_e;

  // Upper funct bits above the shamt must select SLLI/SRLI (zero) or SRAI.
  function automatic logic shift_funct_ok(input logic [5:0] hi, input logic [2:0] funct3);
    logic [6:0] srli;
    logic [6:0] srai;
    srli = FUNCT7_SRLI;
    srai = FUNCT7_SRAI;
    return (hi == srli[6:1]) || ((hi == srai[6:1]) && (funct3 == 3'b101));
  endfunction

endpackage

`default_nettype wire

// File: rtl/imm_decode_pipe_extract.sv
// ============================================================================
// Module : imm_extract
// Desc   : Combinational immediate / format / illegal decode for RV32I or RV64I.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module imm_extract
  import opcode_type::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i32;
  logic [31:0] imm_s32;
  logic [31:0] imm_b32;
  logic [31:0] imm_u32;
  logic [31:0] imm_j32;
  logic        is_shift;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  assign imm_i32 = {{20{instr[31]}}, instr[31:20]};
  assign imm_s32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u32 = {instr[31:12], 12'h000};
  assign imm_j32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        imm = XLEN'($signed(imm_u32));
        fmt = FMT_U;
      end
      OP_JAL: begin
        imm = XLEN'($signed(imm_j32));
        fmt = FMT_J;
      end
      OP_JALR, OP_LOAD, MISC_MEM: begin
        imm = XLEN'($signed(imm_i32));
        fmt = FMT_I;
      end
      OP_STORE: begin
        imm = XLEN'($signed(imm_s32));
        fmt = FMT_S;
      end
      OP_BRANCH: begin
        imm = XLEN'($signed(imm_b32));
        fmt = FMT_B;
      end
      OP_IMM: begin
        if (is_shift) begin
          fmt = FMT_SHAMT;
          if (XLEN == 64) begin
            imm     = XLEN'(instr[25:20]);
            illegal = !shift_funct_ok(instr[31:26], funct3);
          end else begin
            imm     = XLEN'(instr[24:20]);
            illegal = instr[25] || !shift_funct_ok(instr[31:26], funct3);
          end
        end else begin
          imm = XLEN'($signed(imm_i32));
          fmt = FMT_I;
        end
      end
      OP_IMM_32: begin
        if (XLEN != 64) begin
          illegal = 1'b1;
        end else if (funct3 == 3'b000) begin
          imm = XLEN'($signed(imm_i32));
          fmt = FMT_I;
        end else if (is_shift) begin
          // Word shifts only have a 5-bit shamt; bit 25 set is a reserved encoding.
          imm     = XLEN'(instr[24:20]);
          fmt     = FMT_SHAMT;
          illegal = instr[25] || !shift_funct_ok(instr[31:26], funct3);
        end else begin
          illegal = 1'b1;
        end
      end
      OP_REG: begin
        illegal = 1'b0;
      end
      OP_32: begin
        illegal = (XLEN != 64);
      end
      SYSTEM: begin
        if (funct3[2]) begin
          imm = XLEN'(instr[19:15]);
          fmt = FMT_ZIMM;
        end else begin
          imm = XLEN'($signed(imm_i32));
          fmt = FMT_I;
        end
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/imm_decode_pipe.sv
// ============================================================================
// Module : imm_decode_pipe
// Desc   : Registered immediate decoder with valid/ready handshake and skid buffer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module imm_decode_pipe
  import opcode_type::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output imm_fmt_e        out_fmt,
  output logic            out_illegal
);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    imm_fmt_e        fmt;
    logic            illegal;
  } entry_t;

  entry_t          buf_q [2];
  entry_t          buf_d [2];
  logic [1:0]      count_q;
  logic [1:0]      count_d;
  entry_t          new_entry;
  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;
  logic            push;
  logic            pop;

  imm_extract #(
    .XLEN (XLEN)
  ) u_imm_extract (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  assign new_entry = '{instr: in_instr, pc: in_pc, imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal};

  generate
    if (DEPTH == 1) begin : g_ready_reg
      assign in_ready = out_ready || !out_valid;
    end else begin : g_ready_skid
      // Depends only on occupancy, which breaks the out_ready -> in_ready path.
      assign in_ready = (count_q < 2'(DEPTH));
    end
  endgenerate

  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    buf_d   = buf_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) buf_d[0] = new_entry;
          else                 buf_d[1] = new_entry;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          buf_d[0] = buf_q[1];
          count_d  = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            buf_d[0] = new_entry;
          end else begin
            buf_d[0] = buf_q[1];
            buf_d[1] = new_entry;
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      count_q  <= count_d;
      buf_q[0] <= buf_d[0];
      buf_q[1] <= buf_d[1];
    end
  end

  assign out_instr   = buf_q[0].instr;
  assign out_pc      = buf_q[0].pc;
  assign out_imm     = buf_q[0].imm;
  assign out_fmt     = buf_q[0].fmt;
  assign out_illegal = buf_q[0].illegal;

endmodule

`default_nettype wire

// File: tb/tb_imm_decode_pipe.sv
// ============================================================================
// Module : tb_imm_decode_pipe
// Desc   : Scoreboard bench for imm_decode_pipe at XLEN=32 and XLEN=64, DEPTH=2.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_imm_decode_pipe;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        out_ready;
  logic        mon_en;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_in_instr, a_in_pc, a_out_instr, a_out_pc, a_out_imm;
  logic [2:0]  a_out_fmt;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_illegal;
  logic [31:0] b_in_instr, b_out_instr;
  logic [63:0] b_in_pc, b_out_pc, b_out_imm;
  logic [2:0]  b_out_fmt;

  exp_t qa[$];
  exp_t qb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  imm_decode_pipe #(.XLEN(32), .DEPTH(2)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr), .in_pc(a_in_pc),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_instr(a_out_instr),
    .out_pc(a_out_pc), .out_imm(a_out_imm), .out_fmt(a_out_fmt), .out_illegal(a_out_illegal)
  );

  imm_decode_pipe #(.XLEN(64), .DEPTH(2)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_pc(b_in_pc),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_instr(b_out_instr),
    .out_pc(b_out_pc), .out_imm(b_out_imm), .out_fmt(b_out_fmt), .out_illegal(b_out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic shift_ok(input logic [31:0] w, input logic [2:0] f3, input bit wide);
    logic [6:0] f7;
    f7 = w[31:25];
    if (wide) return (f7[6:1] == 6'h00) || (f7[6:1] == 6'h10 && f3 == 3'd5);
    return (f7 == 7'h00) || (f7 == 7'h20 && f3 == 3'd5);
  endfunction

  function automatic exp_t ref_dec(input logic [31:0] w, input int xlen, input logic [63:0] pc);
    exp_t   e;
    longint v;
    logic [2:0] f3;
    f3 = w[14:12];
    v = 0;
    e.fmt = 3'd0;
    e.ill = 1'b0;
    case (w[6:0])
      7'h37, 7'h17: begin v = $signed({w[31:12], 12'h000}); e.fmt = 3'd4; end
      7'h6F:        begin v = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0}); e.fmt = 3'd5; end
      7'h67, 7'h03, 7'h0F: begin v = $signed(w[31:20]); e.fmt = 3'd1; end
      7'h23:        begin v = $signed({w[31:25], w[11:7]}); e.fmt = 3'd2; end
      7'h63:        begin v = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0}); e.fmt = 3'd3; end
      7'h13: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.fmt = 3'd6;
          if (xlen == 64) begin v = {58'd0, w[25:20]}; e.ill = !shift_ok(w, f3, 1'b1); end
          else            begin v = {59'd0, w[24:20]}; e.ill = !shift_ok(w, f3, 1'b0); end
        end else begin
          v = $signed(w[31:20]); e.fmt = 3'd1;
        end
      end
      7'h1B: begin
        if (xlen == 32) e.ill = 1'b1;
        else if (f3 == 3'd0) begin v = $signed(w[31:20]); e.fmt = 3'd1; end
        else if (f3 == 3'd1 || f3 == 3'd5) begin
          v = {59'd0, w[24:20]}; e.fmt = 3'd6; e.ill = !shift_ok(w, f3, 1'b0);
        end else e.ill = 1'b1;
      end
      7'h33: e.ill = 1'b0;
      7'h3B: e.ill = (xlen == 32);
      7'h73: begin
        if (f3[2]) begin v = {59'd0, w[19:15]}; e.fmt = 3'd7; end
        else       begin v = $signed(w[31:20]); e.fmt = 3'd1; end
      end
      default: e.ill = 1'b1;
    endcase
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    e.imm   = v;
    e.instr = w;
    e.pc    = pc;
    return e;
  endfunction

  // Scoreboards: compare the current head, then apply this cycle's handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      check("a_valid", a_out_valid, qa.size() != 0);
      check("a_ready", a_in_ready, qa.size() < 2);
      if (qa.size() != 0 && a_out_valid) begin
        check("a_instr", a_out_instr, qa[0].instr);
        check("a_pc", a_out_pc, qa[0].pc);
        check("a_imm", a_out_imm, qa[0].imm);
        check("a_fmt", a_out_fmt, qa[0].fmt);
        check("a_ill", a_out_illegal, qa[0].ill);
      end
      if (!rst_n || flush) qa.delete();
      else begin
        logic acc;
        acc = a_in_valid && (qa.size() < 2);
        if (qa.size() != 0 && out_ready) void'(qa.pop_front());
        if (acc) qa.push_back(ref_dec(a_in_instr, 32, {32'd0, a_in_pc}));
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("b_valid", b_out_valid, qb.size() != 0);
      check("b_ready", b_in_ready, qb.size() < 2);
      if (qb.size() != 0 && b_out_valid) begin
        check("b_instr", b_out_instr, qb[0].instr);
        check("b_pc", b_out_pc, qb[0].pc);
        check("b_imm", b_out_imm, qb[0].imm);
        check("b_fmt", b_out_fmt, qb[0].fmt);
        check("b_ill", b_out_illegal, qb[0].ill);
      end
      if (!rst_n || flush) qb.delete();
      else begin
        logic acc;
        acc = b_in_valid && (qb.size() < 2);
        if (qb.size() != 0 && out_ready) void'(qb.pop_front());
        if (acc) qb.push_back(ref_dec(b_in_instr, 64, b_in_pc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic direct_a(input logic [31:0] w, input logic [63:0] imm, input logic [2:0] fmt,
                          input logic ill, input string tag);
    tick();
    a_in_valid = 1'b1; a_in_instr = w; a_in_pc = $urandom;
    tick();
    a_in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_valid"}, a_out_valid, 1'b1);
    check({tag, "_imm"}, a_out_imm, imm);
    check({tag, "_fmt"}, a_out_fmt, fmt);
    check({tag, "_ill"}, a_out_illegal, ill);
  endtask

  task automatic direct_b(input logic [31:0] w, input logic [63:0] imm, input logic [2:0] fmt,
                          input logic ill, input string tag);
    tick();
    b_in_valid = 1'b1; b_in_instr = w; b_in_pc = {$urandom, $urandom};
    tick();
    b_in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_valid"}, b_out_valid, 1'b1);
    check({tag, "_imm"}, b_out_imm, imm);
    check({tag, "_fmt"}, b_out_fmt, fmt);
    check({tag, "_ill"}, b_out_illegal, ill);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [15];
    logic [31:0] w;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h0F, 7'h13, 7'h13, 7'h1B,
            7'h33, 7'h3B, 7'h73, 7'h23, 7'h63, 7'h7F};
    w = $urandom;
    w[6:0] = ops[$urandom_range(0, 14)];
    if ($urandom_range(0, 1) == 1) begin w[31] = 1'b0; w[29:26] = 4'h0; end
    if ($urandom_range(0, 1) == 1) w[25] = 1'b0;
    return w;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic accepted;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; mon_en = 1'b0;
    a_in_valid = 1'b0; a_in_instr = '0; a_in_pc = '0;
    b_in_valid = 1'b0; b_in_instr = '0; b_in_pc = '0;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    @(negedge clk);
    check("rst_valid", a_out_valid, 1'b0);
    check("rst_imm", a_out_imm, 64'd0);
    check("rst_fmt", a_out_fmt, 3'd0);
    check("rst_ill", a_out_illegal, 1'b0);
    check("rst_instr", a_out_instr, 64'd0);
    check("rst_pc", a_out_pc, 64'd0);
    check("rst_b_imm", b_out_imm, 64'd0);
    check("rst_b_pc", b_out_pc, 64'd0);
    tick();
    rst_n = 1'b1; out_ready = 1'b1;

    direct_a(32'hFFF00093, 64'hFFFF_FFFF, 3'd1, 1'b0, "addi_m1");
    direct_a(32'h4030D093, 64'd3, 3'd6, 1'b0, "srai3");
    direct_a(32'hFE000EE3, 64'hFFFF_FFFC, 3'd3, 1'b0, "beq_m4");
    direct_a(32'h0080006F, 64'd8, 3'd5, 1'b0, "jal8");
    direct_a(32'h3002D073, 64'd5, 3'd7, 1'b0, "csrrwi5");
    direct_a(32'h0200D09B, 64'd0, 3'd0, 1'b1, "srliw_x32");
    direct_a(32'h02809093, 64'd8, 3'd6, 1'b1, "slli40_x32");
    direct_b(32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0, "lui_x64");
    direct_b(32'h0200D09B, 64'd0, 3'd6, 1'b1, "srliw32_x64");
    direct_b(32'h02809093, 64'h28, 3'd6, 1'b0, "slli40_x64");
    direct_b(32'h0010809B, 64'd1, 3'd1, 1'b0, "addiw1");
    direct_b(32'hFE113C23, 64'hFFFF_FFFF_FFFF_FFF8, 3'd2, 1'b0, "sd_m8");

    // Backpressure: third push must stall, head must hold.
    tick();
    out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_instr = 32'h00100093; a_in_pc = 32'h100;
    tick();
    a_in_instr = 32'h00200093; a_in_pc = 32'h104;
    tick();
    a_in_instr = 32'h00300093; a_in_pc = 32'h108;
    @(negedge clk);
    check("bp_ready", a_in_ready, 1'b0);
    check("bp_head", a_out_instr, 32'h00100093);
    tick();
    @(negedge clk);
    check("bp_hold", a_out_instr, 32'h00100093);
    check("bp_hold_ready", a_in_ready, 1'b0);
    tick();
    out_ready = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (a_in_ready) begin accepted = 1'b1; break; end
    end
    check("bp_accept", accepted, 1'b1);
    tick();
    a_in_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("bp_drained", a_out_valid, 1'b0);

    // Flush with two buffered entries and a same-cycle push.
    tick();
    out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_instr = 32'h00400093;
    tick();
    a_in_instr = 32'h00500093;
    tick();
    flush = 1'b1; a_in_instr = 32'h00600093;
    tick();
    flush = 1'b0; a_in_valid = 1'b0;
    @(negedge clk);
    check("fl_valid", a_out_valid, 1'b0);
    check("fl_ready", a_in_ready, 1'b1);
    tick();
    flush = 1'b1; a_in_valid = 1'b1; a_in_instr = 32'h00700093;
    tick();
    flush = 1'b0; a_in_valid = 1'b0;
    @(negedge clk);
    check("fl_empty_push", a_out_valid, 1'b0);

    // Reset in the middle of traffic.
    tick();
    a_in_valid = 1'b1; a_in_instr = 32'h00800093;
    b_in_valid = 1'b1; b_in_instr = 32'h00900093;
    tick();
    tick();
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_valid", a_out_valid, 1'b0);
    check("mrst_instr", a_out_instr, 64'd0);
    check("mrst_imm", a_out_imm, 64'd0);
    check("mrst_b_valid", b_out_valid, 1'b0);
    check("mrst_b_instr", b_out_instr, 64'd0);
    out_ready = 1'b1;
    direct_a(32'h00A00093, 64'd10, 3'd1, 1'b0, "post_rst");

    // Random traffic with random backpressure and occasional flush.
    for (int i = 0; i < 400; i++) begin
      tick();
      a_in_valid = ($urandom_range(0, 3) != 0);
      a_in_instr = rand_instr();
      a_in_pc    = $urandom;
      b_in_valid = ($urandom_range(0, 3) != 0);
      b_in_instr = rand_instr();
      b_in_pc    = {$urandom, $urandom};
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 40) == 0);
    end
    tick();
    a_in_valid = 1'b0; b_in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("end_a_empty", a_out_valid, 1'b0);
    check("end_b_empty", b_out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imm_decode_pipe.md
Name: imm_decode_pipe

Overview:
Parametrised, registered successor to the combinational immediate generator.
- Accepts instructions through a valid/ready handshake and decodes the immediate, its format and an illegal-encoding flag for RV32I or RV64I.
- Holds results in a 2-entry skid buffer so the decode stage can stall without dropping or duplicating instructions.
- Sits between fetch and register-read/execute; supports pipeline flush.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64; controls immediate sign-extension width and shamt width.
- DEPTH, 2, output buffer entries; legal values 1 (plain register, in_ready = out_ready || !out_valid) or 2 (skid buffer).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- flush  in  1  drops all buffered entries and any same-cycle input.
- in_valid  in  1  instruction present.
- in_ready  out  1  block can accept; asserted when buffer count < DEPTH.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  instruction PC, carried through.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head.
- out_instr  out  32  carried instruction.
- out_pc  out  XLEN  carried PC.
- out_imm  out  XLEN  decoded immediate.
- out_fmt  out  3  imm_fmt_e: NONE=0 I=1 S=2 B=3 U=4 J=5 SHAMT=6 ZIMM=7.
- out_illegal  out  1  opcode/funct encoding not supported for this XLEN.

Behaviour:
- Reset (rst_n=0 at edge): count=0; out_valid=0; out_imm=0; out_fmt=NONE; out_illegal=0; out_instr=0; out_pc=0. Reset mid-stream discards all entries.
- Push when in_valid && in_ready; pop when out_valid && out_ready. Latency is 1 cycle: a pushed instruction appears on out_* the next cycle if the buffer was empty or popped.
- In-order FIFO. Simultaneous push and pop with count=1 keeps count=1, and the head advances to the new entry. With count=DEPTH, in_ready=0 and no push occurs even if out_ready=1 in that cycle; in_ready is not combinationally dependent on out_ready when DEPTH=2.
- out_* are stable while out_valid && !out_ready.
- flush=1: count becomes 0 next cycle and out_valid drops. The same-cycle push is ignored. Flush wins over push and pop.
- Decode is combinational on in_instr; the result is registered into the buffer.
  - U (LUI 0110111, AUIPC 0010111): {instr[31:12],12'h0}, sign-extended to XLEN.
  - J (1101111): {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}, sign-extended.
  - I (JALR 1100111, LOAD 0000011, MISC-MEM 0001111, OP-IMM non-shift): instr[31:20], sign-extended.
  - S (0100011): {instr[31:25],instr[11:7]}, sign-extended.
  - B (1100011): {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}, sign-extended.
  - SHAMT (OP-IMM funct3=001/101): zero-extended shamt, instr[24:20] when XLEN=32 and instr[25:20] when XLEN=64.
    - Illegal when XLEN=32 and instr[25]=1.
    - Illegal when funct7 upper bits are neither 0 nor 0100000 (SRAI), or are 0100000 with funct3=001.
  - OP-IMM-32 (0011011): legal only when XLEN=64. ADDIW uses fmt I. Shifts use 5-bit shamt; illegal if instr[25]=1. When XLEN=32 the whole opcode is illegal.
  - ZIMM (SYSTEM 1110011, funct3[2]=1): zero-extended instr[19:15]. SYSTEM with funct3[2]=0 uses fmt I.
  - OP (0110011) and OP-32 (XLEN=64 only): fmt NONE, imm 0, legal.
  - Any other opcode: fmt NONE, imm 0, illegal=1.
  - Illegal entries still flow through the handshake.

Decomposition:
- Extend shared package opcode_type with:
  - imm_fmt_e;
  - opcodes OP_IMM_32, OP_32, SYSTEM, MISC_MEM;
  - funct7 constants for SRAI/SRLI.
- Sub-module imm_extract (combinational, parameter XLEN; instr in; imm, fmt, illegal out).
- imm_decode_pipe owns the buffer, count and flush logic.

Test Plan:
- XLEN=32: push 0xFFF00093 (ADDI -1) -> next cycle out_imm=0xFFFFFFFF, fmt=I, illegal=0. Then push 0x4030D093 (SRAI 3) -> imm=0x00000003, fmt=SHAMT.
- XLEN=32: 0xFE000EE3 (BEQ -4) -> imm=0xFFFFFFFC, fmt=B. 0x0080006F (JAL +8) -> imm=0x8, fmt=J. 0x3002D073 (CSRRWI zimm 5) -> imm=0x5, fmt=ZIMM.
- XLEN=64: 0x800000B7 (LUI) -> imm=0xFFFFFFFF80000000, fmt=U. 0x0200D09B (SRLIW shamt 32) -> illegal=1. Same word with XLEN=32 -> illegal=1.
- Backpressure, DEPTH=2: hold out_ready=0, push 3 back-to-back -> in_ready drops after 2 accepts and out_* stay stable. Release out_ready -> entries drain in order with no loss or duplicate.
- Flush with count=2 plus same-cycle valid push -> next cycle out_valid=0, in_ready=1, and the flushed instruction never appears.
- Assert rst_n=0 mid-stream for 1 cycle -> all outputs at reset values next cycle; first push after release appears with 1-cycle latency.
